mul_div_unit: RTL and testbench



---
 rtl/mul_div_unit.sv | 224 ++++++++++++++++++++++
 tb/tb_mul_div_unit.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Purpose : iterative RV32M multiply/divide unit (radix-2 shift-add multiply, restoring divide).
// Latency : 33 cycles start-to-write; divide-by-zero and signed-overflow divides write after 1 cycle.
// Backpressure: none; busy blocks issue, and start is ignored while an operation is in flight.
//
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   start, funct3, rd           issue request, operation select, destination index
//   readData1, readData2        rs1 / rs2 operands, sampled with start only
//   busy                        operation in flight (cycle after accept through the write cycle)
//   regWrite, writeRegister,    single-cycle register-file write port; index/data hold their
//   writeData                   last values between writes
module mul_div_unit (
   input  logic        clk,
   input  logic        resetn,
   input  logic        start,
   input  logic [2:0]  funct3,
   input  logic [4:0]  rd,
   input  logic [31:0] readData1,
   input  logic [31:0] readData2,
   output logic        busy,
   output logic        regWrite,
   output logic [4:0]  writeRegister,
   output logic [31:0] writeData
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [2:0] F_MULH   = 3'b001;
   localparam logic [2:0] F_MULHSU = 3'b010;
   localparam logic [2:0] F_DIV    = 3'b100;
   localparam logic [2:0] F_REM    = 3'b110;

   state_t      state_q,          state_d;
   logic [4:0]  cnt_q,            cnt_d;
   logic [63:0] acc_q,            acc_d;
   logic [31:0] opa_q,            opa_d;
   logic [2:0]  f3_q,             f3_d;
   logic [4:0]  rd_q,             rd_d;
   logic        neg_q,            neg_d;
   logic        busy_q,           busy_d;
   logic        reg_write_q,      reg_write_d;
   logic [4:0]  write_register_q, write_register_d;
   logic [31:0] write_data_q,     write_data_d;

   // ------------------------------------------------------------------
   // Issue-side decode (operates on the live inputs, used only in IDLE)
   // ------------------------------------------------------------------
   logic        a_signed, b_signed;
   logic        sa, sb;
   logic [31:0] mag_a, mag_b;
   logic        neg_in;
   logic        div_zero, div_ovf;
   logic [31:0] special_res;

   always_comb begin
      a_signed = (funct3 == F_MULH) || (funct3 == F_MULHSU) ||
                 (funct3 == F_DIV)  || (funct3 == F_REM);
      b_signed = (funct3 == F_MULH) || (funct3 == F_DIV) || (funct3 == F_REM);
      sa       = a_signed & readData1[31];
      sb       = b_signed & readData2[31];
      mag_a    = sa ? (32'd0 - readData1) : readData1;
      mag_b    = sb ? (32'd0 - readData2) : readData2;
      // A remainder takes the dividend's sign; products and quotients take the XOR.
      neg_in   = (funct3 == F_REM) ? sa : (sa ^ sb);
      div_zero = funct3[2] && (readData2 == 32'd0);
      div_ovf  = ((funct3 == F_DIV) || (funct3 == F_REM)) &&
                 (readData1 == 32'h8000_0000) && (readData2 == 32'hFFFF_FFFF);
      if (div_zero) begin
         special_res = funct3[1] ? readData1 : 32'hFFFF_FFFF;
      end else begin
         special_res = funct3[1] ? 32'd0 : 32'h8000_0000;
      end
   end

   // ------------------------------------------------------------------
   // One iteration of the datapath, shared register acc_q:
   //   multiply: acc = {partial product high, multiplier shifting out}
   //   divide  : acc = {partial remainder,    dividend shifting out / quotient shifting in}
   // ------------------------------------------------------------------
   logic [32:0] mul_sum;
   logic [63:0] mul_next;
   logic [32:0] div_shift;
   logic [32:0] div_diff;
   logic [63:0] div_next;
   logic [63:0] step_next;
   logic [63:0] prod_fix;
   logic [31:0] div_raw;
   logic [31:0] final_res;

   always_comb begin
      mul_sum   = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? opa_q : 32'd0)};
      mul_next  = {mul_sum, acc_q[31:1]};

      div_shift = {acc_q[63:32], acc_q[31]};
      div_diff  = div_shift - {1'b0, opa_q};
      // The shifted remainder is always below twice the divisor, so bit 32 of
      // the difference is a clean borrow flag.
      if (!div_diff[32]) begin
         div_next = {div_diff[31:0], acc_q[30:0], 1'b1};
      end else begin
         div_next = {div_shift[31:0], acc_q[30:0], 1'b0};
      end

      step_next = f3_q[2] ? div_next : mul_next;

      prod_fix  = neg_q ? (64'd0 - step_next) : step_next;
      div_raw   = f3_q[1] ? step_next[63:32] : step_next[31:0];

      if (f3_q[2]) begin
         final_res = neg_q ? (32'd0 - div_raw) : div_raw;
      end else if (f3_q[1:0] == 2'b00) begin
         final_res = prod_fix[31:0];
      end else begin
         final_res = prod_fix[63:32];
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d          = state_q;
      cnt_d            = cnt_q;
      acc_d            = acc_q;
      opa_d            = opa_q;
      f3_d             = f3_q;
      rd_d             = rd_q;
      neg_d            = neg_q;
      busy_d           = busy_q;
      reg_write_d      = 1'b0;
      write_register_d = write_register_q;
      write_data_d     = write_data_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               f3_d   = funct3;
               rd_d   = rd;
               neg_d  = neg_in;
               busy_d = 1'b1;
               if (div_zero || div_ovf) begin
                  state_d          = S_DONE;
                  reg_write_d      = (rd != 5'd0);
                  write_register_d = rd;
                  write_data_d     = special_res;
               end else begin
                  state_d = S_RUN;
                  cnt_d   = 5'd31;
                  if (funct3[2]) begin
                     opa_d = mag_b;
                     acc_d = {32'd0, mag_a};
                  end else begin
                     opa_d = mag_a;
                     acc_d = {32'd0, mag_b};
                  end
               end
            end
         end

         S_RUN: begin
            acc_d = step_next;
            cnt_d = cnt_q - 5'd1;
            if (cnt_q == 5'd0) begin
               // Final iteration and sign fixup land on the same edge.
               state_d          = S_DONE;
               reg_write_d      = (rd_q != 5'd0);
               write_register_d = rd_q;
               write_data_d     = final_res;
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end

         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // State and registered outputs
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q          <= S_IDLE;
         cnt_q            <= 5'd0;
         acc_q            <= 64'd0;
         opa_q            <= 32'd0;
         f3_q             <= 3'd0;
         rd_q             <= 5'd0;
         neg_q            <= 1'b0;
         busy_q           <= 1'b0;
         reg_write_q      <= 1'b0;
         write_register_q <= 5'd0;
         write_data_q     <= 32'd0;
      end else begin
         state_q          <= state_d;
         cnt_q            <= cnt_d;
         acc_q            <= acc_d;
         opa_q            <= opa_d;
         f3_q             <= f3_d;
         rd_q             <= rd_d;
         neg_q            <= neg_d;
         busy_q           <= busy_d;
         reg_write_q      <= reg_write_d;
         write_register_q <= write_register_d;
         write_data_q     <= write_data_d;
      end
   end

   assign busy          = busy_q;
   assign regWrite      = reg_write_q;
   assign writeRegister = write_register_q;
   assign writeData     = write_data_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Purpose : scoreboard bench for mul_div_unit; stimulus pushes expected writes, a monitor pops them.
// Latency : expects writes 33 cycles after start (1 cycle for special-case divides).
// Backpressure: stimulus waits out each operation; busy is checked every cycle.
module tb_mul_div_unit;

   logic        clk;
   logic        resetn;
   logic        start;
   logic [2:0]  funct3;
   logic [4:0]  rd;
   logic [31:0] readData1;
   logic [31:0] readData2;
   logic        busy;
   logic        regWrite;
   logic [4:0]  writeRegister;
   logic [31:0] writeData;

   mul_div_unit dut (
      .clk           (clk),
      .resetn        (resetn),
      .start         (start),
      .funct3        (funct3),
      .rd            (rd),
      .readData1     (readData1),
      .readData2     (readData2),
      .busy          (busy),
      .regWrite      (regWrite),
      .writeRegister (writeRegister),
      .writeData     (writeData)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned edge_cnt = 0;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
      logic [31:0] edge_no;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Monitor: every write pulse must match the oldest expected entry.
   logic prev_wr = 1'b0;
   always @(negedge clk) begin
      if (regWrite === 1'b1) begin
         exp_t e;
         chk("regwrite_single_cycle", {31'd0, prev_wr}, 32'd0);
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write actual=rd%0d/%h required=no write", writeRegister, writeData);
         end else begin
            e = exp_q.pop_front();
            chk("write_reg",   {27'd0, writeRegister}, {27'd0, e.rd});
            chk("write_data",  writeData, e.data);
            chk("write_cycle", edge_cnt, e.edge_no);
         end
      end
      prev_wr = (regWrite === 1'b1);
   end

   // Drive a start in the next cycle; e0 is the edge count seen during cycle 1.
   task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rdi, output int unsigned e0);
      @(negedge clk);
      start     = 1'b1;
      funct3    = f3;
      rd        = rdi;
      readData1 = a;
      readData2 = b;
      @(posedge clk);
      #1;
      start     = 1'b0;
      readData1 = 32'hDEAD_BEEF;
      readData2 = 32'hDEAD_BEEF;
      e0        = edge_cnt;
   endtask

   task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rdi, input logic [31:0] res,
                         input bit special, input int pulse_at);
      int unsigned e0;
      int          last;
      exp_t        e;
      last = special ? 1 : 33;
      issue(f3, a, b, rdi, e0);
      if (rdi != 5'd0) begin
         e.rd      = rdi;
         e.data    = res;
         e.edge_no = e0 + last - 1;
         exp_q.push_back(e);
      end
      for (int k = 1; k <= last + 1; k++) begin
         @(negedge clk);
         chk({name, "_busy"}, {31'd0, busy}, (k <= last) ? 32'd1 : 32'd0);
         if (k == pulse_at) begin
            start     = 1'b1;
            funct3    = 3'b000;
            rd        = 5'd9;
            readData1 = 32'd3;
            readData2 = 32'd3;
         end else if (k == pulse_at + 1) begin
            start = 1'b0;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned e0;
      resetn    = 1'b0;
      start     = 1'b0;
      funct3    = 3'd0;
      rd        = 5'd0;
      readData1 = 32'd0;
      readData2 = 32'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_busy",   {31'd0, busy},          32'd0);
      chk("rst_wr",     {31'd0, regWrite},      32'd0);
      chk("rst_wreg",   {27'd0, writeRegister}, 32'd0);
      chk("rst_wdata",  writeData,              32'd0);
      resetn = 1'b1;

      run_op("mul",     3'b000, 32'd7,         32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 1'b0, 0);
      run_op("mulh",    3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6,  32'h4000_0000, 1'b0, 0);
      run_op("mulhu",   3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE, 1'b0, 0);
      run_op("mulhsu",  3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFF, 1'b0, 0);
      run_op("div",     3'b100, 32'hFFFF_FFF9, 32'd2,         5'd10, 32'hFFFF_FFFD, 1'b0, 0);
      run_op("rem",     3'b110, 32'hFFFF_FFF9, 32'd2,         5'd11, 32'hFFFF_FFFF, 1'b0, 0);
      run_op("divu",    3'b101, 32'd100,       32'd7,         5'd12, 32'd14,        1'b0, 0);
      run_op("remu",    3'b111, 32'd100,       32'd7,         5'd13, 32'd2,         1'b0, 0);
      run_op("div0",    3'b100, 32'd5,         32'd0,         5'd14, 32'hFFFF_FFFF, 1'b1, 0);
      run_op("remu0",   3'b111, 32'd5,         32'd0,         5'd15, 32'd5,         1'b1, 0);
      run_op("divovf",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000, 1'b1, 0);
      run_op("removf",  3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'd0,         1'b1, 0);
      run_op("mulpulse",3'b000, 32'd1234,      32'd1000,      5'd18, 32'd1234000,   1'b0, 10);
      run_op("mulrd0",  3'b000, 32'd6,         32'd7,         5'd0,  32'd42,        1'b0, 0);

      // Reset in cycle 10 of a DIVU: no write may appear for it.
      issue(3'b101, 32'd100, 32'd7, 5'd20, e0);
      for (int k = 1; k <= 10; k++) @(negedge clk);
      resetn = 1'b0;
      #1;
      chk("abort_busy",  {31'd0, busy},          32'd0);
      chk("abort_wr",    {31'd0, regWrite},      32'd0);
      chk("abort_wreg",  {27'd0, writeRegister}, 32'd0);
      chk("abort_wdata", writeData,              32'd0);
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      repeat (30) @(negedge clk);
      chk("abort_idle_busy", {31'd0, busy}, 32'd0);
      run_op("divu_post", 3'b101, 32'd100, 32'd7, 5'd21, 32'd14, 1'b0, 0);

      repeat (5) @(negedge clk);
      chk("sb_empty", exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
